// File: rtl/uart_tx_fifo_drain.sv
// FIFO read-side UART transmitter: pops one word per frame and shifts it out
// as start / data (LSB first) / optional parity / stop bits.
module uart_tx_fifo_drain #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int NCW = $clog2(WIDTH + 2);

    if (CLK_DIV < 2 || PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_tx_fifo_drain: illegal CLK_DIV, PARITY or STOP_BITS");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t           r_state;
    logic [BCW-1:0]   r_baud;
    logic [NCW-1:0]   r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_par;
    logic             r_tx;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_bit_end;
    logic             w_last_stop;
    logic             w_pop;
    logic [WIDTH-1:0] w_shift_nxt;

    assign w_bit_end   = (r_baud == BCW'(CLK_DIV - 1));
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == NCW'(STOP_BITS - 1));
    // Held low during reset so the FIFO never loses a word to an ignored edge.
    assign w_pop       = ((r_state == S_IDLE) || w_last_stop) && enable && !fifo_empty && !rst;
    assign w_shift_nxt = r_shift >> 1;

    assign fifo_rd_en = w_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Pulse lands on the final stop cycle, so it is armed one cycle early.
            r_frame_done <= (r_state == S_STOP) && (r_baud == BCW'(CLK_DIV - 2)) &&
                            (r_bit == NCW'(STOP_BITS - 1));
            if (w_pop) begin
                r_state <= S_START;
                r_baud  <= '0;
                r_bit   <= '0;
                r_shift <= fifo_data;
                r_par   <= (PARITY == 2) ? ~(^fifo_data) : (^fifo_data);
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_tx   <= 1'b1;
                r_busy <= 1'b0;
            end else begin
                r_baud <= w_bit_end ? '0 : r_baud + BCW'(1);
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                            r_tx    <= r_shift[0];
                        end
                        S_DATA: begin
                            r_shift <= w_shift_nxt;
                            if (r_bit == NCW'(WIDTH - 1)) begin
                                r_bit <= '0;
                                if (PARITY != 0) begin
                                    r_state <= S_PAR;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state <= S_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit <= r_bit + NCW'(1);
                                r_tx  <= w_shift_nxt[0];
                            end
                        end
                        S_PAR: begin
                            r_state <= S_STOP;
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                        end
                        S_STOP: begin
                            if (r_bit == NCW'(STOP_BITS - 1)) begin
                                r_state <= S_IDLE;
                                r_bit   <= '0;
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_bit <= r_bit + NCW'(1);
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Read-side consumer for the asynchronous FIFO. Sits in the FIFO read clock domain.
- Pops words through the FIFO's rd_en/empty/rd_data interface and serialises each word onto an asynchronous serial line (UART framing).
- Frame format: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
- Intended as the transmit back-end of the FIFO-buffered serial path.

Parameters:
WIDTH, 8, data bits per frame; must equal the FIFO WIDTH.
CLK_DIV, 16, clk cycles per serial bit; minimum 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  single clock; same clock as the FIFO rd_clk.
rst  input  1  asynchronous, active-high reset.
enable  input  1  permits popping new words; sampled only at pop decision points.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  WIDTH  FIFO read data; valid whenever fifo_empty=0.
fifo_rd_en  output  1  FIFO pop strobe; one clk cycle per word.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
Clock and reset:
- One clock: clk. Reset rst is asynchronous and active-high.
- Reset values: tx=1, busy=0, frame_done=0, fifo_rd_en=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.

State machine:
- States: IDLE, START, DATA, PAR, STOP.
- Baud counter counts 0..CLK_DIV-1. A bit ends when the count reaches CLK_DIV-1.

Pop rule:
- fifo_rd_en is combinational and equals pop_ok AND enable AND !fifo_empty.
- pop_ok is true in IDLE, or in the final cycle of the final stop bit.
- On the clk edge where fifo_rd_en=1:
  - fifo_data is captured into the shift register.
  - The next state is START and the baud counter is cleared.
- Never more than one pop per frame. FIFO empty updates one cycle after a pop, which is harmless because the next pop opportunity is at least one frame away.

Line timing:
- The cycle after the pop edge, tx=0 for CLK_DIV cycles (START).
- DATA: WIDTH bits, LSB first, CLK_DIV cycles each. Bit counter 0..WIDTH-1. Shift right at the end of each bit.
- PAR (only if PARITY != 0): one bit.
  - Even parity: XOR of the captured data bits.
  - Odd parity: inverted XOR.
  - Parity is computed from the word captured at the pop, not the shifted register.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
- Frame length: (1 + WIDTH + (PARITY != 0) + STOP_BITS) * CLK_DIV cycles.

End of frame:
- Last STOP cycle with pop conditions met: pop, go to START. Back-to-back frames with no idle gap.
- Otherwise go to IDLE.
- frame_done pulses on that last STOP cycle in both cases.
- busy = (state != IDLE). busy stays 1 across back-to-back frames.
- tx is registered (glitch-free) and equals 1 in IDLE.

Boundary conditions:
- enable deasserted mid-frame: the current frame completes unchanged; no further pops until enable=1.
- fifo_empty=1 in IDLE: no pop, tx stays 1, busy=0.
- rst asserted mid-frame: all outputs go to reset values immediately; the in-flight word is dropped, not re-read. tx returns high asynchronously.
- fifo_data changing while not popping is ignored; only the pop-edge value is transmitted.
- Illegal parameter values (CLK_DIV<2, PARITY>2, STOP_BITS not 1 or 2) are flagged by an elaboration-time check.

Test Plan:
- Single word, no parity (WIDTH=8, CLK_DIV=4, PARITY=0, STOP_BITS=1): FIFO holds 0xA5, enable=1.
  - fifo_rd_en pulses once.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles).
  - frame_done at cycle 40 after the pop; busy high for exactly 40 cycles; tx=1 afterwards.
- Back-to-back, same configuration: FIFO holds 0x00 then 0xFF.
  - Pops at cycle 0 and cycle 40, with the second pop coincident with the first frame_done.
  - 80 contiguous cycles with no idle gap; busy never drops between frames.
- Parity: word 0x07.
  - PARITY=1 gives parity bit 1; PARITY=2 gives parity bit 0.
  - With STOP_BITS=2, the frame is 48 cycles at CLK_DIV=4.
- Empty and enable gating:
  - fifo_empty=1 for 100 cycles: no fifo_rd_en, tx=1, busy=0.
  - enable dropped at cycle 10 of a frame: frame completes (frame_done at cycle 40), no second pop despite fifo_empty=0.
  - enable re-raised: pop on the next cycle.
- Reset mid-frame: rst pulsed during DATA bit 3.
  - tx=1 and busy=0 at once.
  - After release with FIFO non-empty, the next word is popped cleanly with a full start bit.
- FIFO integration: drive the asynchronous FIFO (write clock 3x faster) with a burst of 16 words, 0x00..0x0F.
  - A serial monitor decodes exactly 0x00..0x0F in order, with no duplicates or losses.
  - fifo_rd_en is never asserted while empty=1.
